branch_ctrl: RTL

Sequences one ARM B/BL instruction from decode through PC redirect. It latches the instruction word, the PC and the NZCV flags, then evaluates the condition field. It computes the target using the 24-bit sign-extend-and-shift-by-2 offset path, then drives the PC load, the link-register write and the pipeline flush in order. The block sits between decode and the fetch/register-file write ports, using a valid/ready request handshake and a one-cycle done strobe.

---
 rtl/branch_pkg.sv | 64 ++++++
 rtl/branch_target_calc.sv | 16 +
 rtl/branch_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types, ARM condition-code constants and the condition-evaluation
// function used by the branch sequencer.
package branch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_LOAD,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [2:0] BRANCH_OPCODE = 3'b101;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // NV falls into the default arm and is never satisfied.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Branch target adder: sign-extended 24-bit word offset added to the
// pipeline-adjusted PC, wrapping modulo 2^32.
module branch_target_calc #(
  parameter logic [31:0] PC_OFFSET = 32'd8
) (
  input  logic [31:0] pc,
  input  logic [23:0] offset,
  output logic [31:0] target
);

  logic [31:0] offset_ext;

  assign offset_ext = {{6{offset[23]}}, offset, 2'b00};
  assign target     = pc + PC_OFFSET + offset_ext;

endmodule

// File: rtl/branch_ctrl.sv
// Sequences a single ARM B/BL from acceptance through PC load, link write,
// pipeline flush and a completion strobe.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] PC_OFFSET    = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [3:0]  flags,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        lr_we,
  output logic [31:0] lr_data,
  output logic        flush,
  output logic        done,
  output logic        taken
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pc_q, pc_d;
  logic [3:0]         flags_q, flags_d;
  logic               taken_q, taken_d;

  branch_target_calc #(
    .PC_OFFSET (PC_OFFSET)
  ) u_target (
    .pc     (pc_q),
    .offset (instr_q[23:0]),
    .target (pc_target)
  );

  assign lr_data = pc_q + 32'd4;

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    flags_d   = flags_q;
    taken_d   = taken_q;
    req_ready = 1'b0;
    pc_load   = 1'b0;
    lr_we     = 1'b0;
    flush     = 1'b0;
    done      = 1'b0;
    taken     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          instr_d = instr;
          pc_d    = pc;
          flags_d = flags;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        taken_d = (instr_q[27:25] == BRANCH_OPCODE) && cond_pass(instr_q[31:28], flags_q);
        state_d = taken_d ? ST_LOAD : ST_DONE;
      end
      ST_LOAD: begin
        pc_load = 1'b1;
        lr_we   = instr_q[24];
        if (FLUSH_CYCLES == 0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        done    = 1'b1;
        taken   = taken_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      flags_q <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      taken_q <= taken_d;
    end
  end

endmodule
